serial_comparator: RTL and testbench
====================================

Name: serial_comparator

Overview:
- Sequential, bit-serial counterpart of the parallel N-bit magnitude comparator.
- Latches two WIDTH-bit unsigned operands on a start handshake and scans them MSB-first, one bit per clock.
- Reports Lesser/Greater/Equal with a one-cycle done pulse.
- Used where area matters more than latency, and as a cross-check against the parallel comparator.

Parameters:
- WIDTH, 32: operand width in bits; legal range 2..64.
- EARLY_EXIT, 1: 1 = finish on the first differing bit; 0 = always scan all WIDTH bits (fixed latency).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, unsigned; sampled when start is accepted
- b  input  WIDTH  operand B, unsigned; sampled when start is accepted
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse: result valid and newly updated
- Lesser  output  1  a < b
- Greater  output  1  a > b
- Equal  output  1  a == b

Behaviour:
- Reset: clk and rst only, one clock domain; reset is synchronous and active-high.
  - All outputs are 0 at reset: busy, done, Lesser, Greater, Equal.
  - FSM goes to IDLE; shift registers and counter are cleared.
- FSM states IDLE, RUN. All outputs are registered.
- IDLE:
  - start=1 at edge E0 is accepted: sa<=a, sb<=b, cnt<=WIDTH, diff<=0, {Lesser,Greater,Equal}<=000, busy<=1, go to RUN.
  - start=0: hold state; results keep their last values.
- RUN, each edge:
  - Compare sa[WIDTH-1] with sb[WIDTH-1].
  - If the bits differ and diff=0: set diff; Greater<=sa MSB; Lesser<=sb MSB.
  - Shift sa and sb left by 1; cnt<=cnt-1.
  - With EARLY_EXIT=1, the first difference ends the scan: busy<=0, done<=1, go to IDLE.
  - When cnt reaches 1 (last bit) with no difference anywhere: Equal<=1, done<=1, busy<=0, go to IDLE.
  - With EARLY_EXIT=0, later differing bits never overwrite the first-difference result.
- Latency: let i be the index of the highest differing bit.
  - done is high in the cycle after edge E_k, counting k edges after E0.
  - EARLY_EXIT=1: k = WIDTH-i. Equal operands: k = WIDTH.
  - EARLY_EXIT=0: k = WIDTH always.
- After done, exactly one of Lesser/Greater/Equal is 1. The result holds until the next start is accepted.
- done lasts exactly one cycle.
- start while busy=1 is ignored: no restart and no queueing.
- start high in the same cycle as done: the FSM is already in IDLE, so start is accepted. Results clear to 000 on that edge.
- start held high continuously: back-to-back scans; a new scan is accepted in every cycle that done is high.
- a and b may change freely while busy=1; only the values sampled at E0 matter.
- rst asserted mid-scan: abort on that edge. No done pulse; all outputs go to 0.

Decomposition:
- Package serial_cmp_pkg:
  - state enum {IDLE, RUN};
  - result encoding constants RES_LT=3'b100, RES_GT=3'b010, RES_EQ=3'b001, as the {Lesser,Greater,Equal} order;
  - function clog2 for the counter width, $clog2(WIDTH+1).
- One natural sub-module: serial_cmp_datapath.
  - Contains the twin shift registers, the down-counter and the MSB compare.
  - Exposes bit_lt, bit_gt and last_bit to the FSM in the top level.

Test Plan:
- Reset then a=2, b=2, one-cycle start, WIDTH=32, EARLY_EXIT=1 -> busy for 32 cycles; done pulse after E32; Equal=1, Lesser=0, Greater=0.
- a=22, b=444 -> highest differing bit 8; done after E24; Lesser=1. Then a=777, b=111 -> differing bit 9; done after E23; Greater=1.
- a=32'hFFFFFFFF, b=32'hFFFFFFFE -> done after E32, Greater=1. Then a=32'h80000000, b=0 -> done after E1, Greater=1.
- EARLY_EXIT=0, a=444, b=555 -> done always after E32; Lesser=1; later differing bits do not change the result.
- Start a=8888, b=8888; pulse start with a=1, b=2 at cycle 5 (ignored); assert rst at cycle 10 -> no done pulse; all outputs 0; a fresh start afterwards gives Equal after E32.
- start held high with alternating operand pairs -> back-to-back scans; results clear to 000 on each acceptance edge; one done per scan; one-hot result checked at every done.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package serial_cmp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Result vectors in {Lesser, Greater, Equal} order.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 32'd1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_cmp_datapath.sv
// Twin MSB-first shift registers, scan down-counter and per-bit MSB compare.
module serial_cmp_datapath
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             bit_lt,
    output logic             bit_gt,
    output logic             last_bit
);

    localparam int unsigned CW = clog2(WIDTH + 1);

    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [CW-1:0]    cnt_r;

    // Operand capture on accept, then one left shift and count-down per scan cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r  <= '0;
            sb_r  <= '0;
            cnt_r <= '0;
        end else if (load) begin
            sa_r  <= a;
            sb_r  <= b;
            cnt_r <= CW'(WIDTH);
        end else if (shift) begin
            sa_r  <= {sa_r[WIDTH-2:0], 1'b0};
            sb_r  <= {sb_r[WIDTH-2:0], 1'b0};
            cnt_r <= cnt_r - CW'(1);
        end else begin
            sa_r  <= sa_r;
            sb_r  <= sb_r;
            cnt_r <= cnt_r;
        end
    end

    assign bit_lt   = ~sa_r[WIDTH-1] &  sb_r[WIDTH-1];
    assign bit_gt   =  sa_r[WIDTH-1] & ~sb_r[WIDTH-1];
    assign last_bit = (cnt_r == CW'(1));

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator: start handshake, MSB-first scan, one-cycle done.
module serial_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             Lesser,
    output logic             Greater,
    output logic             Equal
);

    state_t     state_r;
    logic       diff_r;
    logic       busy_r;
    logic       done_r;
    logic [2:0] res_r;

    logic       load_s;
    logic       shift_s;
    logic       bit_lt_s;
    logic       bit_gt_s;
    logic       last_bit_s;
    logic       first_diff_s;
    logic       finish_s;

    assign load_s       = (state_r == IDLE) && start;
    assign shift_s      = (state_r == RUN);
    assign first_diff_s = (bit_lt_s | bit_gt_s) & ~diff_r;
    assign finish_s     = (first_diff_s && EARLY_EXIT) || last_bit_s;

    serial_cmp_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .shift    (shift_s),
        .a        (a),
        .b        (b),
        .bit_lt   (bit_lt_s),
        .bit_gt   (bit_gt_s),
        .last_bit (last_bit_s)
    );

    // Control FSM; the first differing bit fixes the result and later bits never overwrite it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            diff_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            res_r   <= RES_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        diff_r  <= 1'b0;
                        res_r   <= RES_NONE;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (first_diff_s) begin
                        diff_r <= 1'b1;
                        res_r  <= bit_gt_s ? RES_GT : RES_LT;
                    end else begin
                        diff_r <= diff_r;
                    end
                    if (finish_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                        if (!diff_r && !first_diff_s) begin
                            res_r <= RES_EQ;
                        end else begin
                            diff_r <= 1'b1;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    res_r   <= RES_NONE;
                end
            endcase
        end
    end

    assign busy                     = busy_r;
    assign done                     = done_r;
    assign {Lesser, Greater, Equal} = res_r;

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized self-checking bench: one fixed-latency and one early-exit comparator against a reference model.
module tb_serial_comparator;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_v [2];
    logic [W-1:0] a_v     [2];
    logic [W-1:0] b_v     [2];
    logic         busy_v  [2];
    logic         done_v  [2];
    logic         lt_v    [2];
    logic         gt_v    [2];
    logic         eq_v    [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // index 0: EARLY_EXIT=0, index 1: EARLY_EXIT=1
    serial_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_fixed (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .Lesser(lt_v[0]), .Greater(gt_v[0]), .Equal(eq_v[0])
    );

    serial_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_early (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .Lesser(lt_v[1]), .Greater(gt_v[1]), .Equal(eq_v[1])
    );

    function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x < y) return 3'b100;
        else if (x > y) return 3'b010;
        else return 3'b001;
    endfunction

    // Edges after acceptance until done: W - (index of highest differing bit) for early exit.
    function automatic int ref_lat(input int m, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        int hi;
        d  = x ^ y;
        hi = -1;
        for (int i = 0; i < W; i++) if (d[i]) hi = i;
        if (m == 0 || hi < 0) return W;
        return W - hi;
    endfunction

    function automatic logic [W-1:0] pick_b(input logic [W-1:0] x);
        int sel;
        logic [W-1:0] y;
        sel = $urandom_range(0, 3);
        case (sel)
            0: y = x;
            1: y = x ^ (32'd1 << $urandom_range(0, W - 1));
            2: y = x ^ (32'hFFFF_FFFF >> $urandom_range(0, W - 1));
            default: y = $urandom;
        endcase
        return y;
    endfunction

    // Entered and left #1 after a rising edge.
    task automatic do_scan(input int m, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [2:0] want;
        int want_k;
        int k;
        want   = ref_res(x, y);
        want_k = ref_lat(m, x, y);
        start_v[m] = 1'b1; a_v[m] = x; b_v[m] = y;
        @(posedge clk); #1;
        start_v[m] = 1'b0; a_v[m] = $urandom; b_v[m] = $urandom;
        n_cmp++;
        if ({busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]} !== 5'b10000) begin
            n_bad++;
            $display("FAIL %s accept: got busy,done,res=%b want 10000", tag,
                     {busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]});
        end
        k = 0;
        while (done_v[m] !== 1'b1 && k < W + 8) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (k !== want_k) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d (a=%h b=%h)", tag, k, want_k, x, y);
        end
        n_cmp++;
        if ({lt_v[m], gt_v[m], eq_v[m]} !== want) begin
            n_bad++;
            $display("FAIL %s result: got %b want %b (a=%h b=%h)", tag, {lt_v[m], gt_v[m], eq_v[m]}, want, x, y);
        end
        n_cmp++;
        if ({busy_v[m], done_v[m]} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s done_busy: got %b want 01", tag, {busy_v[m], done_v[m]});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]} !== {2'b00, want}) begin
            n_bad++;
            $display("FAIL %s hold: got %b want %b", tag, {busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]}, {2'b00, want});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if ({busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]} !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %b want 00000", m, {busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]});
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_scan(1, 32'd2, 32'd2, "eq_2_2");
        do_scan(1, 32'd22, 32'd444, "lt_22_444");
        do_scan(1, 32'd777, 32'd111, "gt_777_111");
        do_scan(1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "gt_lsb");
        do_scan(1, 32'h8000_0000, 32'd0, "gt_msb");
        do_scan(0, 32'd444, 32'd555, "fixed_lt");
        do_scan(0, 32'h0000_00F0, 32'h0000_000F, "fixed_gt_later_lt");
        do_scan(0, 32'h1234_5678, 32'h1234_5678, "fixed_eq");
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        for (int n = 0; n < 30; n++) begin
            for (int m = 0; m < 2; m++) begin
                x = $urandom;
                do_scan(m, x, pick_b(x), m == 1 ? "rand_early" : "rand_fixed");
            end
        end
    endtask

    task automatic test_abort();
        int seen;
        start_v[1] = 1'b1; a_v[1] = 32'd8888; b_v[1] = 32'd8888;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start_v[1] = 1'b1; a_v[1] = 32'd1; b_v[1] = 32'd2;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        n_cmp++;
        if ({busy_v[1], done_v[1], lt_v[1], gt_v[1], eq_v[1]} !== 5'b10000) begin
            n_bad++;
            $display("FAIL abort_ignored_start: got %b want 10000", {busy_v[1], done_v[1], lt_v[1], gt_v[1], eq_v[1]});
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({busy_v[1], done_v[1], lt_v[1], gt_v[1], eq_v[1]} !== 5'b00000) begin
            n_bad++;
            $display("FAIL abort_outputs: got %b want 00000", {busy_v[1], done_v[1], lt_v[1], gt_v[1], eq_v[1]});
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_v[1] !== 1'b0 || busy_v[1] !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
        end
        do_scan(1, 32'd8888, 32'd8888, "after_abort");
    endtask

    task automatic test_back_to_back(input int m);
        logic [W-1:0] xs [6];
        logic [W-1:0] ys [6];
        logic [2:0]   want;
        int k;
        for (int j = 0; j < 6; j++) begin
            xs[j] = $urandom;
            ys[j] = (j % 2 == 0) ? pick_b(xs[j]) : xs[j] ^ (32'd1 << $urandom_range(0, W - 1));
        end
        start_v[m] = 1'b1; a_v[m] = xs[0]; b_v[m] = ys[0];
        @(posedge clk); #1;
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if ({busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]} !== 5'b10000) begin
                n_bad++;
                $display("FAIL b2b[%0d] accept %0d: got %b want 10000", m, j, {busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]});
            end
            a_v[m] = (j < 5) ? xs[j+1] : 32'd0;
            b_v[m] = (j < 5) ? ys[j+1] : 32'd0;
            want = ref_res(xs[j], ys[j]);
            k = 0;
            while (done_v[m] !== 1'b1 && k < W + 8) begin
                @(posedge clk); #1;
                k++;
            end
            n_cmp++;
            if (k !== ref_lat(m, xs[j], ys[j])) begin
                n_bad++;
                $display("FAIL b2b[%0d] latency %0d: got %0d want %0d", m, j, k, ref_lat(m, xs[j], ys[j]));
            end
            n_cmp++;
            if ({lt_v[m], gt_v[m], eq_v[m]} !== want) begin
                n_bad++;
                $display("FAIL b2b[%0d] result %0d: got %b want %b", m, j, {lt_v[m], gt_v[m], eq_v[m]}, want);
            end
            if (j == 5) start_v[m] = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]} !== {2'b00, ref_res(xs[5], ys[5])}) begin
            n_bad++;
            $display("FAIL b2b[%0d] final: got %b want %b", m, {busy_v[m], done_v[m], lt_v[m], gt_v[m], eq_v[m]},
                     {2'b00, ref_res(xs[5], ys[5])});
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            start_v[m] = 1'b0;
            a_v[m]     = '0;
            b_v[m]     = '0;
        end
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back(1);
        test_back_to_back(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
